cnn_layer_sequencer: RTL and testbench

Parametrised top-level controller for the CNN inference chain: conv, pool, fc, relu, then UART transmit.
Generalises the single-image, single-kernel flow to NUM_IMAGES images and NUM_CHANNELS kernel channels per image.
Drives the external layer engines with start/done handshakes, enforces a per-layer timeout, scores results against expected labels, and streams each class to the UART transmitter over valid/ready.

---
 rtl/cnn_layer_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// Sequences conv/pool/fc per kernel channel, then relu and one UART byte per image,
// with a per-layer done timeout and a running count of correctly classified images.
module cnn_layer_sequencer #(
  parameter int unsigned NUM_IMAGES      = 4,
  parameter int unsigned NUM_CHANNELS    = 2,
  parameter int unsigned CLASSIFICATIONS = 10,
  parameter int unsigned CLASS_W         = 4,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned IW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       conv_start,
  output logic                       pool_start,
  output logic                       fc_start,
  output logic                       relu_start,
  input  logic                       conv_done,
  input  logic                       pool_done,
  input  logic                       fc_done,
  input  logic                       relu_done,
  output logic [CW-1:0]              channel_sel,
  output logic                       fc_first,
  output logic [IW-1:0]              image_idx,
  input  logic [CLASS_W-1:0]         expected_class,
  input  logic [CLASS_W-1:0]         relu_class,
  input  logic [CLASSIFICATIONS-1:0] relu_onehot,
  output logic [CLASSIFICATIONS-1:0] led,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [IW:0]                match_count,
  output logic [3:0]                 state,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned MW      = IW + 1;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_CONV = 4'd1;
  localparam logic [3:0] S_POOL = 4'd2;
  localparam logic [3:0] S_FC   = 4'd3;
  localparam logic [3:0] S_RELU = 4'd4;
  localparam logic [3:0] S_TX   = 4'd5;
  localparam logic [3:0] S_HOLD = 4'd6;
  localparam logic [3:0] S_DONE = 4'd7;
  localparam logic [3:0] S_ERR  = 4'd8;

  logic [3:0]                 state_nxt;
  logic                       conv_start_nxt, pool_start_nxt, fc_start_nxt, relu_start_nxt;
  logic                       fc_first_nxt, tx_valid_nxt, busy_nxt, done_nxt, error_nxt;
  logic [CW-1:0]              channel_nxt;
  logic [IW-1:0]              image_nxt;
  logic [MW-1:0]              match_nxt;
  logic [7:0]                 tx_data_nxt;
  logic [CLASSIFICATIONS-1:0] led_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic                       tmo_hit;

  // Next state and next value of every registered output
  always_comb begin
    state_nxt   = state;
    channel_nxt = channel_sel;
    image_nxt   = image_idx;
    match_nxt   = match_count;
    tx_valid_nxt = tx_valid;
    tx_data_nxt = tx_data;
    led_nxt     = led;
    cnt_nxt     = cnt + CNT_W'(1);
    tmo_hit     = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          channel_nxt = '0;
          image_nxt   = '0;
          match_nxt   = '0;
          state_nxt   = S_CONV;
        end
      end
      // The *_start flag marks the first cycle in a layer state, where done is ignored
      S_CONV: begin
        if (conv_done && !conv_start) state_nxt = S_POOL;
        else if (tmo_hit)             state_nxt = S_ERR;
      end
      S_POOL: begin
        if (pool_done && !pool_start) state_nxt = S_FC;
        else if (tmo_hit)             state_nxt = S_ERR;
      end
      S_FC: begin
        if (fc_done && !fc_start) begin
          if (channel_sel < CW'(NUM_CHANNELS - 1)) begin
            channel_nxt = channel_sel + CW'(1);
            state_nxt   = S_CONV;
          end else begin
            state_nxt = S_RELU;
          end
        end else if (tmo_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_RELU: begin
        if (relu_done && !relu_start) begin
          state_nxt    = S_TX;
          led_nxt      = relu_onehot;
          tx_data_nxt  = 8'(relu_class);
          tx_valid_nxt = 1'b1;
          if ((relu_class == expected_class) && (match_count != MW'(NUM_IMAGES)))
            match_nxt = match_count + MW'(1);
        end else if (tmo_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_TX: begin
        if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          if (image_idx < IW'(NUM_IMAGES - 1)) begin
            image_nxt   = image_idx + IW'(1);
            channel_nxt = '0;
            state_nxt   = S_CONV;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt != state) cnt_nxt = '0;

    // FC->CONV is a state change too, so every layer entry produces a fresh pulse
    conv_start_nxt = (state_nxt == S_CONV) && (state != S_CONV);
    pool_start_nxt = (state_nxt == S_POOL) && (state != S_POOL);
    fc_start_nxt   = (state_nxt == S_FC)   && (state != S_FC);
    relu_start_nxt = (state_nxt == S_RELU) && (state != S_RELU);
    fc_first_nxt   = fc_start_nxt && (channel_nxt == '0);
    busy_nxt       = !(state_nxt inside {S_IDLE, S_DONE, S_ERR});
    done_nxt       = (state_nxt == S_DONE);
    error_nxt      = (state_nxt == S_ERR);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      conv_start  <= 1'b0;
      pool_start  <= 1'b0;
      fc_start    <= 1'b0;
      relu_start  <= 1'b0;
      fc_first    <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      led         <= '1;
      channel_sel <= '0;
      image_idx   <= '0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      conv_start  <= conv_start_nxt;
      pool_start  <= pool_start_nxt;
      fc_start    <= fc_start_nxt;
      relu_start  <= relu_start_nxt;
      fc_first    <= fc_first_nxt;
      tx_valid    <= tx_valid_nxt;
      tx_data     <= tx_data_nxt;
      led         <= led_nxt;
      channel_sel <= channel_nxt;
      image_idx   <= image_nxt;
      match_count <= match_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer: engine/UART responders plus an
// expected-sequence model built from image/channel loops.
module tb_cnn_layer_sequencer;
  localparam int NI = 4, NC = 2, NCLS = 10, CLW = 4, HOLD = 16, TMO = 1024;
  localparam int IW = 2, CW = 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic conv_start, pool_start, fc_start, relu_start;
  logic conv_done = 1'b0, pool_done = 1'b0, fc_done = 1'b0, relu_done = 1'b0;
  logic [CW-1:0] channel_sel;
  logic fc_first;
  logic [IW-1:0] image_idx;
  logic [CLW-1:0] expected_class = '0, relu_class = '0;
  logic [NCLS-1:0] relu_onehot = '0, led;
  logic tx_valid, tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic [IW:0] match_count;
  logic [3:0] state;
  logic busy, done, error;

  int errors = 0, checks = 0;

  // Responder configuration, written only by the test tasks
  bit auto_en = 1'b1, lat_rand = 1'b0, rdy_rand = 1'b0;
  int lat_fix = 3, drop_layer = -1, drop_image = -1, stall_cycles = 0;
  logic [3:0] inj = '0;
  int cls_tab[NI] = '{2, 2, 2, 2};
  int lab_tab[NI] = '{2, 2, 2, 2};

  // Responder/monitor state, written only by the always blocks
  int cyc = 0, tx_wait = 0, last_hs = 0;
  bit hs_valid = 1'b0;
  int pend[4] = '{0, 0, 0, 0};
  int last_start_cyc[4] = '{0, 0, 0, 0};
  int start_log[$], hold_q[$];
  logic [7:0] tx_log[$];

  // Model outputs
  int exp_starts[$];
  logic [7:0] exp_tx[$];
  int exp_match;
  logic [NCLS-1:0] exp_led;

  cnn_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .conv_start(conv_start), .pool_start(pool_start), .fc_start(fc_start), .relu_start(relu_start),
    .conv_done(conv_done), .pool_done(pool_done), .fc_done(fc_done), .relu_done(relu_done),
    .channel_sel(channel_sel), .fc_first(fc_first), .image_idx(image_idx),
    .expected_class(expected_class), .relu_class(relu_class), .relu_onehot(relu_onehot),
    .led(led), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .match_count(match_count), .state(state), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int enc(int l, logic f, int img, int ch);
    return (l << 8) | (int'(f) << 7) | (img << 3) | ch;
  endfunction

  // Engines, UART sink and start/handshake logging, all away from the active edge
  always @(negedge clk) begin
    logic [3:0] st, dn;
    st = {relu_start, fc_start, pool_start, conv_start};
    dn = '0;
    for (int l = 0; l < 4; l++) begin
      if (pend[l] > 0) begin
        pend[l]--;
        if (pend[l] == 0) dn[l] = 1'b1;
      end
      if (st[l]) begin
        start_log.push_back(enc(l, fc_first, int'(image_idx), int'(channel_sel)));
        last_start_cyc[l] = cyc;
        if (auto_en && !(l == drop_layer && int'(image_idx) == drop_image))
          pend[l] = lat_rand ? int'($urandom_range(1, 6)) : lat_fix;
      end
    end
    if (st[0]) begin
      if (hs_valid && image_idx != '0) hold_q.push_back(cyc - last_hs);
      hs_valid = 1'b0;
    end
    conv_done = dn[0] | inj[0];
    pool_done = dn[1] | inj[1];
    fc_done   = dn[2] | inj[2];
    relu_done = dn[3] | inj[3];
    tx_ready = (tx_wait >= stall_cycles) && (rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    if (tx_valid) tx_wait++; else tx_wait = 0;
    if (tx_valid && tx_ready) begin
      tx_log.push_back(tx_data);
      last_hs  = cyc + 1;
      hs_valid = 1'b1;
    end
    relu_class     = CLW'(cls_tab[image_idx]);
    expected_class = CLW'(lab_tab[image_idx]);
    relu_onehot    = NCLS'(1) << cls_tab[image_idx];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected start sequence, bytes and score from the image/channel loops
  task automatic build_model();
    int m;
    m = 0;
    exp_starts.delete();
    exp_tx.delete();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NC; c++) begin
        exp_starts.push_back(enc(0, 1'b0, i, c));
        exp_starts.push_back(enc(1, 1'b0, i, c));
        exp_starts.push_back(enc(2, c == 0, i, c));
      end
      exp_starts.push_back(enc(3, 1'b0, i, NC - 1));
      exp_tx.push_back(8'(cls_tab[i]));
      if (cls_tab[i] == lab_tab[i]) m++;
    end
    exp_match = (m > NI) ? NI : m;
    exp_led = NCLS'(1) << cls_tab[NI-1];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({state, conv_start, pool_start, fc_start, relu_start, fc_first, tx_valid, busy, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got state=%0d flags=%b want all zero", state,
               {conv_start, pool_start, fc_start, relu_start, fc_first, tx_valid, busy, done, error});
    end
    checks++;
    if (led !== '1 || {tx_data, channel_sel, image_idx, match_count} !== '0) begin
      errors++;
      $display("FAIL reset_data: led=%h tx=%h ch=%0d img=%0d mc=%0d want led=3ff rest 0",
               led, tx_data, channel_sel, image_idx, match_count);
    end
    rst = 1'b0;
    repeat (5) step();
    checks++;
    if (state !== 4'd0 || start_log.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: state=%0d starts=%0d want 0/0", state, start_log.size());
    end
  endtask

  // Nominal, mislabelled and randomized full runs against the model
  task automatic test_runs();
    for (int sc = 0; sc < 5; sc++) begin
      int sb, tb, n;
      bit to;
      lat_rand = (sc >= 2);
      rdy_rand = (sc >= 2);
      for (int i = 0; i < NI; i++) begin
        if (sc < 2) begin
          cls_tab[i] = 2;
          lab_tab[i] = (sc == 1 && i == 1) ? 7 : 2;
        end else begin
          cls_tab[i] = int'($urandom_range(0, NCLS - 1));
          lab_tab[i] = ($urandom_range(0, 1) == 1) ? cls_tab[i] : int'($urandom_range(0, NCLS - 1));
        end
      end
      build_model();
      sb = start_log.size();
      tb = tx_log.size();
      start = 1'b1;
      step();
      start = 1'b0;
      to = 1'b1;
      for (int k = 0; k < 5000; k++) begin
        step();
        start = (sc >= 2 && busy && $urandom_range(0, 7) == 0);
        if (done) begin to = 1'b0; break; end
      end
      start = 1'b0;
      checks++;
      if (to) begin errors++; $display("FAIL run%0d_timeout: done never rose within 5000 cycles", sc); end
      n = start_log.size() - sb;
      checks++;
      if (n != exp_starts.size()) begin
        errors++;
        $display("FAIL run%0d_start_count: got %0d want %0d", sc, n, exp_starts.size());
      end
      for (int i = 0; i < n && i < exp_starts.size(); i++) begin
        checks++;
        if (start_log[sb+i] != exp_starts[i]) begin
          errors++;
          $display("FAIL run%0d_start[%0d]: got %h want %h", sc, i, start_log[sb+i], exp_starts[i]);
        end
      end
      checks++;
      if (tx_log.size() - tb != NI) begin
        errors++;
        $display("FAIL run%0d_tx_count: got %0d want %0d", sc, tx_log.size() - tb, NI);
      end
      for (int i = 0; i < NI && tb + i < tx_log.size(); i++) begin
        checks++;
        if (tx_log[tb+i] !== exp_tx[i]) begin
          errors++;
          $display("FAIL run%0d_tx[%0d]: got %h want %h", sc, i, tx_log[tb+i], exp_tx[i]);
        end
      end
      checks++;
      if (int'(match_count) != exp_match || led !== exp_led) begin
        errors++;
        $display("FAIL run%0d_score: mc=%0d led=%h want mc=%0d led=%h", sc, match_count, led, exp_match, exp_led);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || state !== 4'd7 || int'(image_idx) != NI - 1) begin
        errors++;
        $display("FAIL run%0d_end: done=%b busy=%b state=%0d img=%0d want 1/0/7/%0d",
                 sc, done, busy, state, image_idx, NI - 1);
      end
    end
    lat_rand = 1'b0;
    rdy_rand = 1'b0;
  endtask

  // Backpressure: 50 refused cycles per byte, then one accept and a 16-cycle gap
  task automatic test_tx_stall();
    int tb, hb;
    bit ok, to;
    logic [7:0] d;
    for (int i = 0; i < NI; i++) begin cls_tab[i] = int'($urandom_range(0, 9)); lab_tab[i] = cls_tab[i]; end
    build_model();
    stall_cycles = 50;
    tb = tx_log.size();
    hb = hold_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (tx_valid) begin to = 1'b0; break; end
    end
    d = tx_data;
    ok = !to;
    for (int k = 0; k < 50; k++) begin
      step();
      if (tx_valid !== 1'b1 || tx_data !== d) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL tx_stall_hold: valid=%b data=%h want 1/%h throughout", tx_valid, tx_data, d); end
    to = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      step();
      if (done) begin to = 1'b0; break; end
    end
    checks++;
    if (to || tx_log.size() - tb != NI) begin
      errors++;
      $display("FAIL tx_stall_count: bytes=%0d timeout=%b want %0d/0", tx_log.size() - tb, to, NI);
    end
    for (int i = 0; i < NI && tb + i < tx_log.size(); i++) begin
      checks++;
      if (tx_log[tb+i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL tx_stall_byte[%0d]: got %h want %h", i, tx_log[tb+i], exp_tx[i]);
      end
    end
    checks++;
    if (hold_q.size() - hb != NI - 1) begin
      errors++;
      $display("FAIL hold_count: got %0d gaps want %0d", hold_q.size() - hb, NI - 1);
    end
    for (int i = hb; i < hold_q.size(); i++) begin
      checks++;
      if (hold_q[i] != HOLD) begin errors++; $display("FAIL hold_len: got %0d want %0d", hold_q[i], HOLD); end
    end
    stall_cycles = 0;
  endtask

  // Missing pool_done on image 2 times out into ERR, then a restart recovers
  task automatic test_timeout();
    int sb;
    bit to;
    for (int i = 0; i < NI; i++) begin cls_tab[i] = i; lab_tab[i] = i; end
    build_model();
    lat_rand = 1'b1;
    drop_layer = 1;
    drop_image = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      step();
      if (error) begin to = 1'b0; break; end
    end
    checks++;
    if (to || cyc - last_start_cyc[1] != TMO) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles (expired=%b) want %0d", cyc - last_start_cyc[1], to, TMO);
    end
    checks++;
    if (state !== 4'd8 || busy !== 1'b0 || done !== 1'b0 || image_idx !== 2'd2 || channel_sel !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: state=%0d busy=%b done=%b img=%0d ch=%0d want 8/0/0/2/0",
               state, busy, done, image_idx, channel_sel);
    end
    sb = start_log.size();
    repeat (30) step();
    checks++;
    if (start_log.size() != sb || state !== 4'd8 || error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_quiet: new starts=%0d state=%0d err=%b want 0/8/1", start_log.size() - sb, state, error);
    end
    drop_layer = -1;
    drop_image = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (error !== 1'b0 || state !== 4'd1 || image_idx !== '0 || match_count !== '0 || conv_start !== 1'b1) begin
      errors++;
      $display("FAIL restart: err=%b state=%0d img=%0d mc=%0d cs=%b want 0/1/0/0/1",
               error, state, image_idx, match_count, conv_start);
    end
    to = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      step();
      if (done) begin to = 1'b0; break; end
    end
    checks++;
    if (to || int'(match_count) != exp_match) begin
      errors++;
      $display("FAIL restart_run: mc=%0d timeout=%b want %0d/0", match_count, to, exp_match);
    end
    lat_rand = 1'b0;
  endtask

  // Hand-driven dones: stray, same-cycle-as-start and on the expiry cycle
  task automatic test_ignored_done();
    auto_en = 1'b0;
    inj = 4'b1111;
    step();
    inj = '0;
    checks++;
    if (state !== 4'd7) begin errors++; $display("FAIL stray_done: state=%0d want 7", state); end
    start = 1'b1;
    step();
    start = 1'b0;
    inj = 4'b0101;
    step();
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL conv_first_cycle: state=%0d want 1", state); end
    inj = 4'b0100;
    step();
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL fc_in_conv: state=%0d want 1", state); end
    inj = 4'b0001;
    step();
    inj = 4'b0010;
    step();
    checks++;
    if (state !== 4'd2) begin errors++; $display("FAIL pool_first_cycle: state=%0d want 2", state); end
    step();
    checks++;
    if (state !== 4'd3 || fc_start !== 1'b1 || fc_first !== 1'b1) begin
      errors++;
      $display("FAIL fc_entry: state=%0d fs=%b ff=%b want 3/1/1", state, fc_start, fc_first);
    end
    inj = 4'b0100;
    step();
    checks++;
    if (state !== 4'd3) begin errors++; $display("FAIL fc_with_start: state=%0d want 3", state); end
    step();
    checks++;
    if (state !== 4'd1 || channel_sel !== 1'b1) begin
      errors++;
      $display("FAIL next_channel: state=%0d ch=%0d want 1/1", state, channel_sel);
    end
    inj = '0;
    step();
    inj = 4'b0001;
    step();
    inj = '0;
    repeat (TMO - 1) step();
    checks++;
    if (state !== 4'd2) begin errors++; $display("FAIL pre_expiry: state=%0d want 2", state); end
    inj = 4'b0010;
    step();
    inj = '0;
    checks++;
    if (state !== 4'd3 || error !== 1'b0) begin
      errors++;
      $display("FAIL done_on_expiry: state=%0d err=%b want 3/0", state, error);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    auto_en = 1'b1;
  endtask

  // Asynchronous reset in the middle of image 1 FC, then nothing afterwards
  task automatic test_reset_mid_run();
    int sb;
    bit to;
    start = 1'b1;
    step();
    start = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      step();
      if (state == 4'd3 && image_idx == 2'd1) begin to = 1'b0; break; end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (to || {state, conv_start, pool_start, fc_start, relu_start, fc_first, tx_valid, busy, done, error} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_ctrl: state=%0d busy=%b reached=%b want 0/0/1", state, busy, !to);
    end
    checks++;
    if (led !== '1 || {tx_data, channel_sel, image_idx, match_count} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_data: led=%h tx=%h ch=%0d img=%0d mc=%0d want 3ff/0/0/0/0",
               led, tx_data, channel_sel, image_idx, match_count);
    end
    sb = start_log.size();
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();
    checks++;
    if (start_log.size() != sb || state !== 4'd0) begin
      errors++;
      $display("FAIL midrun_after: new starts=%0d state=%0d want 0/0", start_log.size() - sb, state);
    end
  endtask

  initial begin
    test_reset();
    test_runs();
    test_tx_stall();
    test_timeout();
    test_ignored_done();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
